// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rv_mem_pkg
// Purpose  : Shared funct3 codes, LSU state encoding and lane helpers for the
//            RV32I MEM stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Legal size/sign code for the direction, and natural alignment satisfied.
  function automatic logic access_legal(input logic [2:0] f3,
                                        input logic       is_store,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for an access of the given size (funct3[1:0]) at offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lsu_load_align
// Purpose  : Combinational load formatter: picks the addressed byte/half
//            from the bus word and sign- or zero-extends it.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module lsu_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension chosen by funct3.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_stage_lsu
// Purpose  : RV32I MEM stage. ALU ops pass straight through; loads/stores
//            run a req/ack bus transaction (IDLE -> REQ -> DONE) while the
//            upstream pipeline is stalled. Flags misaligned/illegal accesses
//            and ack timeouts.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_stage_lsu
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] ALURes_in,
  input  logic [31:0] StoreData_in,
  input  logic [4:0]  Rd_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MemData_out,
  output logic [31:0] ALURes_out,
  output logic [4:0]  Rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        stall_out,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      alures_q;
  logic [4:0]       rd_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      memdata_q;
  logic             err_q;

  logic             mem_op;
  logic             legal;
  logic [31:0]      load_fmt;

  assign mem_op = valid_in & (MemRead_in | MemWrite_in);
  assign legal  = access_legal(Funct3_in, MemWrite_in, ALURes_in[1:0]);

  lsu_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (off_q),
    .funct3  (f3_q),
    .data    (load_fmt)
  );

  // Output mux per state; everything is held at zero while reset is asserted.
  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 32'd0;
    dmem_wdata   = 32'd0;
    dmem_be      = 4'd0;
    MemData_out  = 32'd0;
    ALURes_out   = 32'd0;
    Rd_out       = 5'd0;
    RegWrite_out = 1'b0;
    MemtoReg_out = 1'b0;
    stall_out    = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!mem_op) begin
            ALURes_out   = ALURes_in;
            Rd_out       = Rd_in;
            RegWrite_out = RegWrite_in & valid_in;
            MemtoReg_out = MemtoReg_in;
          end else if (!legal) begin
            misalign_o = 1'b1;
          end else begin
            stall_out = 1'b1;
          end
        end
        REQ: begin
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = {alures_q[31:2], 2'b00};
          dmem_wdata = wdata_q;
          dmem_be    = be_q;
          stall_out  = 1'b1;
        end
        DONE: begin
          MemData_out  = memdata_q;
          ALURes_out   = alures_q;
          Rd_out       = rd_q;
          RegWrite_out = regwrite_q & ~err_q;
          MemtoReg_out = memtoreg_q;
          bus_err_o    = err_q;
        end
        default: ;
      endcase
    end
  end

  // Transaction sequencing and capture of the instruction being serviced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alures_q   <= 32'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      memdata_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && legal) begin
            alures_q   <= ALURes_in;
            rd_q       <= Rd_in;
            regwrite_q <= RegWrite_in;
            memtoreg_q <= MemtoReg_in;
            f3_q       <= Funct3_in;
            off_q      <= ALURes_in[1:0];
            we_q       <= MemWrite_in;
            be_q       <= lane_be(Funct3_in[1:0], ALURes_in[1:0]);
            wdata_q    <= lane_wdata(Funct3_in[1:0], StoreData_in);
            err_q      <= 1'b0;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem_ack) begin
            memdata_q <= load_fmt;
            err_q     <= 1'b0;
            state     <= DONE;
          end else if (cnt == LAST_CNT) begin
            memdata_q <= 32'd0;
            err_q     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mem_stage_lsu
// Purpose  : Directed self-checking bench for mem_stage_lsu with a DONE-cycle
//            scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] ALURes_in;
  logic [31:0] StoreData_in;
  logic [4:0]  Rd_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  Funct3_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MemData_out;
  logic [31:0] ALURes_out;
  logic [4:0]  Rd_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic        stall_out;
  logic        misalign_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ALURes_in    (ALURes_in),
    .StoreData_in (StoreData_in),
    .Rd_in        (Rd_in),
    .RegWrite_in  (RegWrite_in),
    .MemtoReg_in  (MemtoReg_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .Funct3_in    (Funct3_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .MemData_out  (MemData_out),
    .ALURes_out   (ALURes_out),
    .Rd_out       (Rd_out),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .stall_out    (stall_out),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  typedef struct {
    logic [31:0] memdata;
    logic        chk_data;
    logic [31:0] alures;
    logic [4:0]  rd;
    logic        regw;
    logic        m2r;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic mr, input logic mw, input logic [2:0] f3);
    valid_in     = v;
    ALURes_in    = a;
    StoreData_in = sd;
    Rd_in        = rd;
    RegWrite_in  = rw;
    MemtoReg_in  = m2r;
    MemRead_in   = mr;
    MemWrite_in  = mw;
    Funct3_in    = f3;
  endtask

  task automatic cycle_start;
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] md, input logic cd, input logic [31:0] a,
                          input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic be);
    exp_t e;
    e.memdata = md; e.chk_data = cd; e.alures = a; e.rd = rd;
    e.regw = rw; e.m2r = m2r; e.berr = be;
    sb.push_back(e);
  endtask

  // Accept cycle: stalled bubble, no request yet.
  task automatic chk_accept(input string tag);
    @(negedge clk);
    chk({tag, ".acc_stall"}, stall_out, 1);
    chk({tag, ".acc_req"}, dmem_req, 0);
    chk({tag, ".acc_regw"}, RegWrite_out, 0);
    chk({tag, ".acc_rd"}, Rd_out, 0);
    chk({tag, ".acc_mis"}, misalign_o, 0);
  endtask

  // Plays the memory side: acks after 'waits' REQ cycles (if ack_en), then
  // checks the DONE cycle against the scoreboard head.
  task automatic run_txn(input string tag, input int waits, input bit ack_en,
                         input logic [31:0] rdata, input int exp_req,
                         input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    int   reqc = 0;
    int   cyc  = 0;
    bit   done = 0;
    exp_t e;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #2;
      dmem_ack   = ack_en && (reqc == waits);
      dmem_rdata = rdata;
      @(negedge clk);
      cyc++;
      if (dmem_req) begin
        reqc++;
        chk({tag, ".req_stall"}, stall_out, 1);
        chk({tag, ".req_addr"}, dmem_addr, addr);
        chk({tag, ".req_we"}, dmem_we, we);
        chk({tag, ".req_regw"}, RegWrite_out, 0);
        if (we) begin
          chk({tag, ".req_be"}, dmem_be, be);
          chk({tag, ".req_wdata"}, dmem_wdata, wdata);
        end
      end else begin
        done = 1;
        chk({tag, ".done_stall"}, stall_out, 0);
        chk({tag, ".req_cycles"}, reqc, exp_req);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL %s.sb_empty observed=0 expected=1 entries", tag);
        end else begin
          e = sb.pop_front();
          if (e.chk_data) chk({tag, ".memdata"}, MemData_out, e.memdata);
          chk({tag, ".alures"}, ALURes_out, e.alures);
          chk({tag, ".rd"}, Rd_out, e.rd);
          chk({tag, ".regw"}, RegWrite_out, e.regw);
          chk({tag, ".m2r"}, MemtoReg_out, e.m2r);
          chk({tag, ".buserr"}, bus_err_o, e.berr);
        end
      end
    end
    dmem_ack = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL %s.timeout observed=no_done expected=done_within_40", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    drive(1, 32'h0000_0010, 32'h0, 5'd5, 1, 0, 0, 0, 3'b000);

    // Reset: outputs forced low regardless of inputs.
    @(negedge clk);
    chk("rst.alures", ALURes_out, 0);
    chk("rst.regw", RegWrite_out, 0);
    chk("rst.rd", Rd_out, 0);
    chk("rst.stall", stall_out, 0);
    chk("rst.req", dmem_req, 0);
    cycle_start;
    rst = 1'b0;

    // Pass-through ADD, with a stray ack that must be ignored.
    cycle_start;
    dmem_ack = 1'b1;
    drive(1, 32'h0000_0010, 32'h0, 5'd5, 1, 0, 0, 0, 3'b000);
    @(negedge clk);
    chk("pt.alures", ALURes_out, 32'h10);
    chk("pt.rd", Rd_out, 5);
    chk("pt.regw", RegWrite_out, 1);
    chk("pt.stall", stall_out, 0);
    chk("pt.req", dmem_req, 0);
    chk("pt.memdata", MemData_out, 0);
    cycle_start;
    dmem_ack = 1'b0;
    drive(0, 32'h0000_0020, 32'h0, 5'd6, 1, 0, 0, 0, 3'b000);
    @(negedge clk);
    chk("bub.regw", RegWrite_out, 0);
    chk("bub.stall", stall_out, 0);
    chk("bub.req", dmem_req, 0);

    // LB zero-wait at byte 3.
    cycle_start;
    drive(1, 32'h0000_1003, 32'h0, 5'd7, 1, 1, 1, 0, 3'b000);
    push_exp(32'hFFFF_FF80, 1, 32'h0000_1003, 5'd7, 1, 1, 0);
    chk_accept("lb");
    run_txn("lb", 0, 1, 32'h80FF_FF7F, 1, 0, 32'h0000_1000, 4'b0, 32'h0);

    // LBU same address.
    cycle_start;
    drive(1, 32'h0000_1003, 32'h0, 5'd8, 1, 1, 1, 0, 3'b100);
    push_exp(32'h0000_0080, 1, 32'h0000_1003, 5'd8, 1, 1, 0);
    chk_accept("lbu");
    run_txn("lbu", 0, 1, 32'h80FF_FF7F, 1, 0, 32'h0000_1000, 4'b0, 32'h0);

    // LH upper half, one wait state.
    cycle_start;
    drive(1, 32'h0000_1002, 32'h0, 5'd10, 1, 1, 1, 0, 3'b001);
    push_exp(32'hFFFF_80FF, 1, 32'h0000_1002, 5'd10, 1, 1, 0);
    chk_accept("lh");
    run_txn("lh", 1, 1, 32'h80FF_FF7F, 2, 0, 32'h0000_1000, 4'b0, 32'h0);

    // SH upper half, three wait states.
    cycle_start;
    drive(1, 32'h0000_2002, 32'hDEAD_BEEF, 5'd9, 0, 0, 0, 1, 3'b001);
    push_exp(32'h0, 0, 32'h0000_2002, 5'd9, 0, 0, 0);
    chk_accept("sh");
    run_txn("sh", 3, 1, 32'h0, 4, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);

    // SB at byte 1, zero-wait.
    cycle_start;
    drive(1, 32'h0000_2001, 32'h1234_56A5, 5'd0, 0, 0, 0, 1, 3'b000);
    push_exp(32'h0, 0, 32'h0000_2001, 5'd0, 0, 0, 0);
    chk_accept("sb");
    run_txn("sb", 0, 1, 32'h0, 1, 1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5);

    // Misaligned LW.
    cycle_start;
    drive(1, 32'h0000_3001, 32'h0, 5'd11, 1, 1, 1, 0, 3'b010);
    @(negedge clk);
    chk("mis.flag", misalign_o, 1);
    chk("mis.req", dmem_req, 0);
    chk("mis.stall", stall_out, 0);
    chk("mis.regw", RegWrite_out, 0);
    chk("mis.rd", Rd_out, 0);
    // Illegal funct3 load.
    cycle_start;
    drive(1, 32'h0000_3000, 32'h0, 5'd12, 1, 1, 1, 0, 3'b011);
    @(negedge clk);
    chk("ill.flag", misalign_o, 1);
    chk("ill.req", dmem_req, 0);
    chk("ill.stall", stall_out, 0);
    chk("ill.regw", RegWrite_out, 0);
    cycle_start;
    drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 3'b000);
    @(negedge clk);
    chk("mis.oneshot", misalign_o, 0);
    chk("mis.noreq", dmem_req, 0);

    // Timeout: LW never acked.
    cycle_start;
    drive(1, 32'h0000_4000, 32'h0, 5'd4, 1, 1, 1, 0, 3'b010);
    push_exp(32'h0, 0, 32'h0000_4000, 5'd4, 0, 1, 1);
    chk_accept("to");
    run_txn("to", 0, 0, 32'h0, 16, 0, 32'h0000_4000, 4'b0, 32'h0);

    // Ack on the final allowed cycle wins over the timeout.
    cycle_start;
    drive(1, 32'h0000_4000, 32'h0, 5'd6, 1, 1, 1, 0, 3'b010);
    push_exp(32'h1234_5678, 1, 32'h0000_4000, 5'd6, 1, 1, 0);
    chk_accept("ack16");
    run_txn("ack16", 15, 1, 32'h1234_5678, 16, 0, 32'h0000_4000, 4'b0, 32'h0);

    // Asynchronous reset two cycles into REQ.
    cycle_start;
    drive(1, 32'h0000_5000, 32'h0, 5'd3, 1, 1, 1, 0, 3'b010);
    chk_accept("ar");
    cycle_start;
    @(negedge clk);
    chk("ar.req1", dmem_req, 1);
    cycle_start;
    @(negedge clk);
    chk("ar.req2", dmem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.req_drop", dmem_req, 0);
    chk("ar.stall_drop", stall_out, 0);
    cycle_start;
    rst = 1'b0;
    drive(1, 32'h0000_0044, 32'h0, 5'd13, 1, 0, 0, 0, 3'b000);
    @(negedge clk);
    chk("ar.pt_alures", ALURes_out, 32'h44);
    chk("ar.pt_rd", Rd_out, 13);
    chk("ar.pt_regw", RegWrite_out, 1);
    chk("ar.pt_stall", stall_out, 0);
    chk("ar.pt_req", dmem_req, 0);

    chk("sb.drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
